output_mems: RTL and testbench

Result-side buffer for the matrix engine. It captures the M×N result matrix C written by the compute datapath, then transmits it row-major as an AXI-Stream master, with TLAST on the final element. It is the transmit-side counterpart of the input matrix loader: the loader receives A and B over AXI-Stream, and this block sends C back out. A 2-entry output buffer hides the one-cycle memory read latency, so it sustains one beat per cycle under continuous TREADY.

---
 rtl/output_mems.sv | 128 ++++++++++++
 tb/tb_output_mems.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_mems.sv
// Result-side buffer: captures the M x N result matrix, then streams it row-major over AXI-Stream.
// A 2-entry skid FIFO hides the one-cycle memory read latency so TREADY=1 gives one beat per cycle.
module output_mems #(
  parameter int OUTW = 28,
  parameter int M = 7,
  parameter int N = 9,
  localparam int C_ADDR_BITS = $clog2(M * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   compute_finished,
  output logic                   out_busy,
  output logic                   output_done,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int MN = M * N;
  localparam int DEPTH = 2 ** C_ADDR_BITS;
  localparam logic [C_ADDR_BITS:0] RD_END = (C_ADDR_BITS + 1)'(MN);
  localparam logic [C_ADDR_BITS:0] RD_LAST = (C_ADDR_BITS + 1)'(MN - 1);

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic [OUTW-1:0]      r_mem [DEPTH];
  logic [OUTW-1:0]      r_rd_data;
  logic                 r_state;
  logic [C_ADDR_BITS:0] r_rd_addr;
  logic                 r_inflight;
  logic                 r_rd_last;
  logic [OUTW-1:0]      r_fifo_data [2];
  logic [1:0]           r_fifo_last;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 r_done;

  logic       w_drain;
  logic       w_valid;
  logic       w_pop;
  logic       w_last_hs;
  logic       w_start;
  logic [2:0] w_occ;
  logic       w_issue;

  always_comb begin
    w_drain   = (r_state == ST_DRAIN);
    w_valid   = (r_count != 2'd0);
    w_pop     = w_valid & AXIS_TREADY;
    w_last_hs = w_pop & r_fifo_last[r_rd_ptr];
    w_start   = ~w_drain & compute_finished;
    // Occupancy after this cycle's pop, counting the read already in flight.
    w_occ     = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    w_issue   = w_drain & (r_rd_addr < RD_END) & (w_occ < 3'd2);
  end

  // Result storage is not reset; writes only land while loading.
  always_ff @(posedge clk) begin
    if (C_wr_en && !w_drain) begin
      r_mem[C_wr_addr] <= C_wr_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_rd_addr[C_ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_LOAD;
      r_rd_addr   <= '0;
      r_inflight  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_fifo_last <= 2'b00;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_done      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_done <= w_last_hs;
      if (w_start) begin
        r_state     <= ST_DRAIN;
        r_rd_addr   <= '0;
        r_inflight  <= 1'b0;
        r_rd_last   <= 1'b0;
        r_fifo_last <= 2'b00;
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_count     <= 2'd0;
      end else if (w_drain) begin
        if (w_last_hs) begin
          r_state <= ST_LOAD;
        end
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
        r_inflight <= w_issue;
        r_rd_last  <= w_issue & (r_rd_addr == RD_LAST);
        if (r_inflight) begin
          r_fifo_data[r_wr_ptr] <= r_rd_data;
          r_fifo_last[r_wr_ptr] <= r_rd_last;
          r_wr_ptr              <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
      end
    end
  end

  always_comb begin
    out_busy    = w_drain;
    output_done = r_done;
    AXIS_TVALID = w_valid;
    AXIS_TDATA  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    AXIS_TLAST  = w_valid & r_fifo_last[r_rd_ptr];
  end

endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems: loads result matrices, streams them out under several TREADY patterns
// and compares every beat against a plain array model of the result memory.
module tb_output_mems;
  localparam int OUTW = 28;
  localparam int M = 7;
  localparam int N = 9;
  localparam int MN = M * N;
  localparam int AW = $clog2(MN);

  logic            clk = 1'b0;
  logic            reset;
  logic            C_wr_en;
  logic [AW-1:0]   C_wr_addr;
  logic [OUTW-1:0] C_wr_data;
  logic            compute_finished;
  logic            out_busy;
  logic            output_done;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY;
  logic            AXIS_TLAST;

  always #5 clk = ~clk;

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk(clk),
    .reset(reset),
    .C_wr_en(C_wr_en),
    .C_wr_addr(C_wr_addr),
    .C_wr_data(C_wr_data),
    .compute_finished(compute_finished),
    .out_busy(out_busy),
    .output_done(output_done),
    .AXIS_TDATA(AXIS_TDATA),
    .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TREADY(AXIS_TREADY),
    .AXIS_TLAST(AXIS_TLAST)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [OUTW-1:0] model_mem [2 ** AW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(AXIS_TVALID), 32'd0);
    chk({tag, "_tlast"}, 32'(AXIS_TLAST), 32'd0);
    chk({tag, "_tdata"}, 32'(AXIS_TDATA), 32'd0);
    chk({tag, "_busy"}, 32'(out_busy), 32'd0);
    chk({tag, "_done"}, 32'(output_done), 32'd0);
  endtask

  // kind 0: 3k-100, 1: k, 2: random, 3: random on even addresses only
  task automatic load_matrix(input int kind);
    for (int k = 0; k < MN; k++) begin
      logic [OUTW-1:0] v;
      case (kind)
        0: v = OUTW'(3 * k - 100);
        1: v = OUTW'(k);
        default: v = OUTW'($urandom);
      endcase
      if (kind != 3 || (k % 2) == 0) begin
        C_wr_en   = 1'b1;
        C_wr_addr = AW'(k);
        C_wr_data = v;
        model_mem[k] = v;
        step();
      end
    end
    C_wr_en = 1'b0;
  endtask

  task automatic start(input logic wr, input int addr, input logic [OUTW-1:0] data);
    compute_finished = 1'b1;
    if (wr) begin
      C_wr_en   = 1'b1;
      C_wr_addr = AW'(addr);
      C_wr_data = data;
      model_mem[addr] = data;
    end
    step();
    compute_finished = 1'b0;
    C_wr_en = 1'b0;
    chk("busy_after_start", 32'(out_busy), 32'd1);
    chk("tvalid_cycle0", 32'(AXIS_TVALID), 32'd0);
    step();
    chk("tvalid_cycle1", 32'(AXIS_TVALID), 32'd0);
    step();
    chk("tvalid_cycle2", 32'(AXIS_TVALID), 32'd1);
    chk("first_beat", 32'(AXIS_TDATA), 32'(model_mem[0]));
  endtask

  // mode 0: TREADY=1, 1: random TREADY, 2: TREADY low for 5 cycles at beat 10
  task automatic stream(input int mode, input int stop_at, input logic garbage);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    int lasts = 0;
    int dones = 0;
    logic rdy;
    while (idx < MN && idx != stop_at && cyc < 3000) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = !(idx == 10 && stall < 5);
      endcase
      AXIS_TREADY = rdy;
      if (garbage) begin
        C_wr_en          = 1'b1;
        C_wr_addr        = AW'($urandom_range(0, MN - 1));
        C_wr_data        = 28'h7FFFFFF;
        compute_finished = 1'($urandom_range(0, 1));
      end
      if (mode != 1) chk("no_bubble", 32'(AXIS_TVALID), 32'd1);
      if (output_done) dones++;
      if (AXIS_TVALID) begin
        chk("tdata", 32'(AXIS_TDATA), 32'(model_mem[idx]));
        chk("tlast", 32'(AXIS_TLAST), 32'(idx == MN - 1));
        if (rdy) begin
          if (AXIS_TLAST) lasts++;
          idx++;
        end else if (mode == 2) begin
          stall++;
        end
      end
      step();
      cyc++;
    end
    AXIS_TREADY      = 1'b0;
    C_wr_en          = 1'b0;
    compute_finished = 1'b0;
    if (idx != stop_at) begin
      chk("beat_count", 32'(idx), 32'(MN));
      if (mode == 0) chk("stream_cycles", 32'(cyc), 32'(MN));
      if (mode == 2) chk("stall_len", 32'(stall), 32'd5);
      chk("tlast_count", 32'(lasts), 32'd1);
      chk("done_early", 32'(dones), 32'd0);
      chk("done_pulse", 32'(output_done), 32'd1);
      chk("busy_clear", 32'(out_busy), 32'd0);
      // back-to-back: a write in the done cycle must commit
      C_wr_en   = 1'b1;
      C_wr_addr = '0;
      C_wr_data = OUTW'(cyc * 7 + 3);
      model_mem[0] = C_wr_data;
      step();
      C_wr_en = 1'b0;
      chk("done_drop", 32'(output_done), 32'd0);
      chk("idle_tvalid", 32'(AXIS_TVALID), 32'd0);
    end
  endtask

  initial begin
    reset            = 1'b1;
    C_wr_en          = 1'b0;
    C_wr_addr        = '0;
    C_wr_data        = '0;
    compute_finished = 1'b0;
    AXIS_TREADY      = 1'b0;
    #1 reset = 1'b0;
    #1 chk_outputs_zero("reset");
    step();
    step();
    reset = 1'b1;
    step();

    // In-order stream with TREADY held high
    load_matrix(0);
    start(1'b0, 0, '0);
    stream(0, -1, 1'b0);

    // Same data (addr 0 rewritten back-to-back) with a 5-cycle stall at beat 10
    start(1'b0, 0, '0);
    stream(2, -1, 1'b0);

    // Random data under random backpressure
    for (int r = 0; r < 4; r++) begin
      load_matrix(2);
      start(1'b0, 0, '0);
      stream(1, -1, 1'b0);
    end

    // Writes and compute_finished during the stream are ignored
    load_matrix(2);
    start(1'b0, 0, '0);
    stream(1, -1, 1'b1);
    load_matrix(3);
    start(1'b0, 0, '0);
    stream(0, -1, 1'b0);

    // Asynchronous reset mid-stream, then a clean reload
    load_matrix(0);
    start(1'b0, 0, '0);
    stream(0, 20, 1'b0);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    step();
    step();
    reset = 1'b1;
    step();
    chk_outputs_zero("after_reset");
    load_matrix(1);
    start(1'b0, 0, '0);
    stream(0, -1, 1'b0);

    // Last write coincides with compute_finished
    load_matrix(2);
    start(1'b1, MN - 1, OUTW'(5));
    stream(0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
